// File: rtl/ssi_pkg.sv
// Shared definitions for the ssi FIFO family (FIFO, reader engine, writer engine).
// Holds the reader's output-buffer depth, the default counter width, the FIFO read
// latency and the occupancy helper used to decide whether another read may be issued.
package ssi_pkg;

  localparam int SSI_RDR_BUF_DEPTH = 2;
  localparam int SSI_DEF_WIDTH     = 32;
  localparam int SSI_DEF_CNTW      = 16;
  localparam int SSI_FIFO_RD_LAT   = 1;

  // Observable reader state: buffered word count and the read-in-flight flag.
  typedef struct packed {
    logic [1:0] cnt;
    logic       inflight;
  } ssi_rdr_dbg_t;

  // True when buffered + in-flight words, after this cycle's pop, leave room for one more.
  // A pop only happens with cnt != 0, so the subtraction never underflows.
  function automatic logic ssi_rdr_has_room(input logic [1:0] cnt,
                                            input logic       inflight,
                                            input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return (occ < 3'(SSI_RDR_BUF_DEPTH));
  endfunction

endpackage

// File: rtl/ssi_fifo_reader_if.sv
// Bus bundle for ssi_fifo_reader: the FIFO read port plus the outgoing stream.
//
// Handshake: the output stream is strict valid/ready. A word transfers on a rising
// edge where out_valid & out_ready are both 1. While out_valid=1 and out_ready=0 the
// reader holds out_valid and out_data unchanged. out_valid never depends on out_ready;
// fifo_rdreq may depend combinationally on out_ready. On the FIFO side, fifo_rdreq is
// only raised while fifo_empty=0, and fifo_q is valid the cycle after fifo_rdreq.
// flush is a synchronous, single-cycle discard request from the consumer side.
interface ssi_fifo_reader_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // Reader side.
  modport master (
    input  flush, fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, out_valid, out_data
  );

  // FIFO + consumer side.
  modport slave (
    output flush, fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, out_valid, out_data
  );
endinterface

// File: rtl/ssi_skid_buf.sv
// Two-entry ring buffer that absorbs the FIFO read latency in the reader engine.
// push writes din at the tail, pop retires the head, flush empties it (flush wins).
// Overflow is prevented by the caller, which never has more than two words pending.
module ssi_skid_buf
  import ssi_pkg::*;
#(
  parameter int WIDTH = SSI_DEF_WIDTH
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [SSI_RDR_BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // Word storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < SSI_RDR_BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ssi_fifo_reader.sv
// Read-side engine for the ssi synchronous FIFO. Issues fifo_rdreq, absorbs the
// one-cycle FIFO read latency in a two-entry buffer and presents the words on a
// valid/ready stream at one word per clock.
// Optional feature: define SSI_RDR_WCNT_EN to add the word_cnt port, a CNTW-bit
// wrapping count of accepted words that only aclr_n clears.
module ssi_fifo_reader
  import ssi_pkg::*;
#(
  parameter int WIDTH = SSI_DEF_WIDTH,
  parameter int CNTW  = SSI_DEF_CNTW
) (
  input  logic                clock,
  input  logic                aclr_n,
  ssi_fifo_reader_if.master   bus,
  output ssi_rdr_dbg_t        dbg
`ifdef SSI_RDR_WCNT_EN
  ,
  output logic [CNTW-1:0]     word_cnt
`endif
);

  logic       pop;
  logic       rdreq;
  logic       inflight;
  logic [1:0] buf_cnt;

  assign pop = bus.out_valid & bus.out_ready;

  // Read whenever the FIFO has data and the word would still fit once it lands.
  // out_ready feeds this path combinationally so a full buffer that is being drained
  // keeps reading without a bubble.
  assign rdreq          = ~bus.fifo_empty & ~bus.flush & ssi_rdr_has_room(buf_cnt, inflight, pop);
  assign bus.fifo_rdreq = rdreq;
  assign bus.out_valid  = (buf_cnt != 2'd0);

  // Remember that a read was issued: its data appears on fifo_q next cycle.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) inflight <= 1'b0;
    else         inflight <= rdreq;
  end

  // The in-flight word is captured unless a flush discards it.
  ssi_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clock  (clock),
    .aclr_n (aclr_n),
    .push   (inflight & ~bus.flush),
    .pop    (pop),
    .flush  (bus.flush),
    .din    (bus.fifo_q),
    .count  (buf_cnt),
    .head   (bus.out_data)
  );

  assign dbg = '{cnt: buf_cnt, inflight: inflight};

`ifdef SSI_RDR_WCNT_EN
  // Count accepted words, wrapping naturally; flush does not touch it.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)  word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + {{(CNTW-1){1'b0}}, 1'b1};
  end
`else
  // CNTW only sizes the counter; nothing to build when it is compiled out.
  if (CNTW < 1) begin : g_cntw_unused
  end
`endif

endmodule
